// File: rtl/vc_sync_fifo.sv
// Multi-channel synchronous FIFO: NUM_VC private circular queues sharing one storage block,
// with per-channel flags, registered credit return, optional empty-channel bypass and sticky error traps.
module vc_sync_fifo #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 4,
    parameter int NUM_VC       = 4,
    parameter int AFULL_THRESH = DEPTH - 1,
    parameter bit BYP_ENABLE   = 1'b0,
    localparam int VC_W  = $clog2(NUM_VC),
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [VC_W-1:0]           push_vc,
    input  logic [WIDTH-1:0]          data_in,
    input  logic                      pop,
    input  logic [VC_W-1:0]           pop_vc,
    input  logic                      err_clr,
    output logic [NUM_VC*WIDTH-1:0]   data_out,
    output logic [NUM_VC-1:0]         empty,
    output logic [NUM_VC-1:0]         full,
    output logic [NUM_VC-1:0]         almost_full,
    output logic [NUM_VC*CNT_W-1:0]   count,
    output logic                      credit_valid,
    output logic [VC_W-1:0]           credit_vc,
    output logic                      err_overflow,
    output logic                      err_underflow
);

    localparam logic [VC_W:0]    VC_LIMIT  = (VC_W + 1)'(NUM_VC);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(AFULL_THRESH);

    logic [WIDTH-1:0] mem    [NUM_VC][DEPTH];
    logic [PTR_W-1:0] rd_ptr [NUM_VC];
    logic [PTR_W-1:0] wr_ptr [NUM_VC];
    logic [CNT_W-1:0] cnt_q  [NUM_VC];

    logic              push_vc_ok;
    logic              pop_vc_ok;
    logic              push_tgt_full;
    logic              pop_tgt_empty;
    logic              same_vc;
    logic              byp;
    logic              push_ok;
    logic              pop_ok;
    logic              push_wr;
    logic              pop_rd;
    logic [NUM_VC-1:0] vc_inc;
    logic [NUM_VC-1:0] vc_dec;

    always_comb begin
        empty       = '0;
        full        = '0;
        almost_full = '0;
        count       = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            empty[v]                   = (cnt_q[v] == '0);
            full[v]                    = (cnt_q[v] == CNT_FULL);
            almost_full[v]             = (cnt_q[v] >= CNT_AFULL);
            count[v*CNT_W +: CNT_W]    = cnt_q[v];
        end
    end

    // Out-of-range channel ids are treated as full/empty so the request is trapped, never applied.
    always_comb begin
        push_vc_ok    = ({1'b0, push_vc} < VC_LIMIT);
        pop_vc_ok     = ({1'b0, pop_vc} < VC_LIMIT);
        push_tgt_full = push_vc_ok ? full[push_vc] : 1'b1;
        pop_tgt_empty = pop_vc_ok ? empty[pop_vc] : 1'b1;
        same_vc       = (push_vc == pop_vc);
        byp           = BYP_ENABLE && push && pop && same_vc && pop_vc_ok && pop_tgt_empty;
        push_ok       = push && push_vc_ok && (!push_tgt_full || (pop && same_vc));
        pop_ok        = pop && pop_vc_ok && (!pop_tgt_empty || byp);
        push_wr       = push_ok && !byp;
        pop_rd        = pop_ok && !byp;
        vc_inc        = '0;
        vc_dec        = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            vc_inc[v] = push_wr && (push_vc == VC_W'(v));
            vc_dec[v] = pop_rd && (pop_vc == VC_W'(v));
        end
    end

    always_comb begin
        data_out = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            data_out[v*WIDTH +: WIDTH] =
                (BYP_ENABLE && empty[v] && push && (push_vc == VC_W'(v))) ? data_in
                                                                          : mem[v][rd_ptr[v]];
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (vc_inc[v]) begin
                mem[v][wr_ptr[v]] <= data_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VC; v++) begin
                rd_ptr[v] <= '0;
                wr_ptr[v] <= '0;
                cnt_q[v]  <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (vc_inc[v]) begin
                    wr_ptr[v] <= (wr_ptr[v] == PTR_LAST) ? '0 : wr_ptr[v] + PTR_W'(1);
                end
                if (vc_dec[v]) begin
                    rd_ptr[v] <= (rd_ptr[v] == PTR_LAST) ? '0 : rd_ptr[v] + PTR_W'(1);
                end
                if (vc_inc[v] && !vc_dec[v]) begin
                    cnt_q[v] <= cnt_q[v] + CNT_W'(1);
                end else if (vc_dec[v] && !vc_inc[v]) begin
                    cnt_q[v] <= cnt_q[v] - CNT_W'(1);
                end
            end
        end
    end

    // A new error in the same cycle as err_clr wins, so no trap is ever silently lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_valid  <= 1'b0;
            credit_vc     <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            credit_valid <= pop_ok;
            if (pop_ok) begin
                credit_vc <= pop_vc;
            end
            if (push && !push_ok) begin
                err_overflow <= 1'b1;
            end else if (err_clr) begin
                err_overflow <= 1'b0;
            end
            if (pop && !pop_ok) begin
                err_underflow <= 1'b1;
            end else if (err_clr) begin
                err_underflow <= 1'b0;
            end
        end
    end

endmodule
